// File: rtl/scan_chain_ctrl.sv
// Shift/capture/unload sequencer for a single scan chain.
// Optional compare-against-expected logic is enabled by defining SCAN_CHAIN_CTRL_COMPARE_EN.
module scan_chain_ctrl #(
    parameter int CHAIN_LEN   = 8,
    parameter int CNT_W       = 4,
    parameter int CAPTURE_CYC = 1
) (
    input  logic                 CK,
    input  logic                 RN,
    input  logic                 start,
    input  logic                 abort,
    input  logic [CHAIN_LEN-1:0] pattern_in,
    input  logic                 scan_out,
    output logic                 scan_en,
    output logic                 scan_in,
    output logic                 busy,
    output logic                 done,
    output logic [CHAIN_LEN-1:0] response
`ifdef SCAN_CHAIN_CTRL_COMPARE_EN
    ,
    input  logic [CHAIN_LEN-1:0] expected,
    output logic                 mismatch
`endif
);

    localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(CHAIN_LEN - 1);
    localparam logic [CNT_W-1:0] CAP_LAST   = CNT_W'(CAPTURE_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SHIFT,
        S_CAPTURE,
        S_UNLOAD,
        S_DONE
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [CHAIN_LEN-1:0]   r_pattern;
    logic [CHAIN_LEN-2:0]   r_acc;
    logic [CHAIN_LEN-1:0]   r_response;
    logic                   r_scan_en;
    logic                   r_scan_in;
    logic                   r_busy;
    logic                   r_done;
    logic                   w_scan_en;
    logic                   w_scan_in;
    logic                   w_busy;
    logic                   w_done;
    logic                   w_accept;
    logic                   w_unload_last;
    logic [CHAIN_LEN-1:0]   w_unload_word;

    assign w_accept      = (r_state == S_IDLE) && start;
    assign w_unload_last = (r_state == S_UNLOAD) && !abort && (r_cnt == SHIFT_LAST);
    assign w_unload_word = {r_acc, scan_out};

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            S_IDLE:    if (start) w_next_state = S_SHIFT;
            S_SHIFT:   if (abort) w_next_state = S_IDLE;
                       else if (r_cnt == SHIFT_LAST) w_next_state = S_CAPTURE;
            S_CAPTURE: if (abort) w_next_state = S_IDLE;
                       else if (r_cnt == CAP_LAST) w_next_state = S_UNLOAD;
            S_UNLOAD:  if (abort) w_next_state = S_IDLE;
                       else if (r_cnt == SHIFT_LAST) w_next_state = S_DONE;
            S_DONE:    w_next_state = S_IDLE;
            default:   w_next_state = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered, so they line up with r_state.
    always_comb begin
        w_scan_en = 1'b0;
        w_scan_in = 1'b0;
        w_busy    = 1'b0;
        w_done    = 1'b0;
        unique case (w_next_state)
            S_SHIFT: begin
                w_scan_en = 1'b1;
                w_busy    = 1'b1;
                w_scan_in = w_accept ? pattern_in[CHAIN_LEN-1] : r_pattern[CHAIN_LEN-1];
            end
            S_CAPTURE: w_busy = 1'b1;
            S_UNLOAD: begin
                w_scan_en = 1'b1;
                w_busy    = 1'b1;
            end
            S_DONE:  w_done = 1'b1;
            default: w_done = 1'b0;
        endcase
    end

    // r_pattern holds the bits still to be presented, next one in the MSB.
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            r_cnt      <= '0;
            r_pattern  <= '0;
            r_acc      <= '0;
            r_response <= '0;
            r_scan_en  <= 1'b0;
            r_scan_in  <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_scan_en <= w_scan_en;
            r_scan_in <= w_scan_in;
            r_busy    <= w_busy;
            r_done    <= w_done;
            if (w_next_state != r_state) begin
                r_cnt <= '0;
            end else if (r_state != S_IDLE && r_state != S_DONE) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_accept) begin
                r_pattern <= {pattern_in[CHAIN_LEN-2:0], 1'b0};
                r_acc     <= '0;
            end else begin
                if (r_state == S_SHIFT) begin
                    r_pattern <= {r_pattern[CHAIN_LEN-2:0], 1'b0};
                end
                if (r_state == S_UNLOAD) begin
                    r_acc <= w_unload_word[CHAIN_LEN-2:0];
                end
            end
            if (w_unload_last) begin
                r_response <= w_unload_word;
            end
        end
    end

    assign scan_en  = r_scan_en;
    assign scan_in  = r_scan_in;
    assign busy     = r_busy;
    assign done     = r_done;
    assign response = r_response;

`ifdef SCAN_CHAIN_CTRL_COMPARE_EN
    logic [CHAIN_LEN-1:0] r_expected;
    logic                 r_mismatch;

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            r_expected <= '0;
            r_mismatch <= 1'b0;
        end else if (w_accept) begin
            r_expected <= expected;
            r_mismatch <= 1'b0;
        end else if (w_unload_last) begin
            r_mismatch <= |(w_unload_word ^ r_expected);
        end
    end

    assign mismatch = r_mismatch;
`endif

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Bench for scan_chain_ctrl: two instances (CAPTURE_CYC=1 and 2), each driving its own modelled scan chain.
module tb_scan_chain_ctrl;
    localparam int N = 8;

    logic           CK = 1'b0;
    logic           RN;
    logic           start;
    logic           abort;
    logic [N-1:0]   pattern_in;
    logic           so   [2];
    logic           se   [2];
    logic           si   [2];
    logic           busy [2];
    logic           done [2];
    logic [N-1:0]   resp [2];
    logic [N-1:0]   chain [2];
    int             mode [2];
    logic [N-1:0]   const_val [2];
    logic [N-1:0]   exp_resp [2];
`ifdef SCAN_CHAIN_CTRL_COMPARE_EN
    logic [N-1:0]   expected;
    logic           mism [2];
`endif
    int total = 0;
    int bad   = 0;

    always #5 CK = ~CK;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        scan_chain_ctrl #(.CHAIN_LEN(N), .CNT_W(4), .CAPTURE_CYC(g + 1)) u_dut (
            .CK(CK), .RN(RN), .start(start), .abort(abort), .pattern_in(pattern_in),
            .scan_out(so[g]), .scan_en(se[g]), .scan_in(si[g]), .busy(busy[g]),
            .done(done[g]), .response(resp[g])
`ifdef SCAN_CHAIN_CTRL_COMPARE_EN
            , .expected(expected), .mismatch(mism[g])
`endif
        );
        assign so[g] = chain[g][N-1];
    end

    // Chain under test: mode 0 = hold (D=Q), 1 = constant D, 2 = inverting (D=~Q).
    always @(posedge CK) begin
        for (int i = 0; i < 2; i++) begin
            if (se[i]) chain[i] <= {chain[i][N-2:0], si[i]};
            else if (mode[i] == 1) chain[i] <= const_val[i];
            else if (mode[i] == 2) chain[i] <= ~chain[i];
        end
    end

    function automatic logic [N-1:0] model(input int md, input logic [N-1:0] pat,
                                           input logic [N-1:0] cv, input int ccyc);
        if (md == 0) return pat;
        if (md == 1) return cv;
        return (ccyc % 2 == 1) ? ~pat : pat;
    endfunction

    // Caller raises start/pattern_in before the call; the next rising edge is the start edge.
    task automatic check_run(input logic [N-1:0] pat, input int a, input int ncyc,
                             input bit keep_start, input string tag);
        int d [2];
        bit ab [2];
        logic [N-1:0] mdl [2];
        logic [N-1:0] exv;
        bit act, e_busy, e_done, e_se, e_si;
        exv = '0;
`ifdef SCAN_CHAIN_CTRL_COMPARE_EN
        exv = expected;
`endif
        for (int i = 0; i < 2; i++) begin
            d[i]   = 2 * N + (i + 1) + 1;
            ab[i]  = (a != 0) && (a <= 2 * N + i + 1);
            mdl[i] = model(mode[i], pat, const_val[i], i + 1);
        end
        @(posedge CK);
        if (!keep_start) begin
            #1 start = 1'b0;
        end
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge CK);
            for (int i = 0; i < 2; i++) begin
                act    = (a == 0) || (c <= a);
                e_busy = act && (c < d[i]);
                e_done = act && (c == d[i]);
                e_se   = act && ((c <= N) || ((c > N + i + 1) && (c < d[i])));
                e_si   = (act && c <= N) ? pat[N-c] : 1'b0;
                if (c == d[i] && !ab[i]) exp_resp[i] = mdl[i];
                total++;
                if (busy[i] !== e_busy) begin
                    bad++;
                    $display("FAIL %s busy inst%0d cyc%0d got=%b want=%b", tag, i, c, busy[i], e_busy);
                end
                total++;
                if (done[i] !== e_done) begin
                    bad++;
                    $display("FAIL %s done inst%0d cyc%0d got=%b want=%b", tag, i, c, done[i], e_done);
                end
                total++;
                if (se[i] !== e_se) begin
                    bad++;
                    $display("FAIL %s scan_en inst%0d cyc%0d got=%b want=%b", tag, i, c, se[i], e_se);
                end
                total++;
                if (si[i] !== e_si) begin
                    bad++;
                    $display("FAIL %s scan_in inst%0d cyc%0d got=%b want=%b", tag, i, c, si[i], e_si);
                end
                total++;
                if (resp[i] !== exp_resp[i]) begin
                    bad++;
                    $display("FAIL %s response inst%0d cyc%0d got=%h want=%h", tag, i, c, resp[i], exp_resp[i]);
                end
`ifdef SCAN_CHAIN_CTRL_COMPARE_EN
                if (c == 1) begin
                    total++;
                    if (mism[i] !== 1'b0) begin
                        bad++;
                        $display("FAIL %s mismatch_clr inst%0d got=%b want=0", tag, i, mism[i]);
                    end
                end
                if (c == d[i] && !ab[i]) begin
                    total++;
                    if (mism[i] !== (mdl[i] != exv)) begin
                        bad++;
                        $display("FAIL %s mismatch inst%0d got=%b want=%b", tag, i, mism[i], (mdl[i] != exv));
                    end
                end
`endif
            end
            abort = (c == a);
        end
    endtask

    task automatic launch(input logic [N-1:0] pat, input int a, input string tag);
        @(negedge CK);
        start      = 1'b1;
        pattern_in = pat;
        check_run(pat, a, 2 * N + 4, 1'b0, tag);
    endtask

    task automatic check_all_zero(input string tag);
        for (int i = 0; i < 2; i++) begin
            total++;
            if ({se[i], si[i], busy[i], done[i], resp[i]} !== '0) begin
                bad++;
                $display("FAIL %s inst%0d got se=%b si=%b busy=%b done=%b resp=%h want all 0",
                         tag, i, se[i], si[i], busy[i], done[i], resp[i]);
            end
`ifdef SCAN_CHAIN_CTRL_COMPARE_EN
            total++;
            if (mism[i] !== 1'b0) begin
                bad++;
                $display("FAIL %s mismatch inst%0d got=%b want=0", tag, i, mism[i]);
            end
`endif
        end
    endtask

    task automatic test_reset();
        RN = 1'b1; start = 1'b0; abort = 1'b0; pattern_in = '0;
        mode[0] = 0; mode[1] = 0; const_val[0] = '0; const_val[1] = '0;
`ifdef SCAN_CHAIN_CTRL_COMPARE_EN
        expected = '0;
`endif
        #2 RN = 1'b0;
        #2 check_all_zero("reset");
        exp_resp[0] = '0; exp_resp[1] = '0;
        @(negedge CK) RN = 1'b1;
        repeat (3) begin
            @(negedge CK);
            for (int i = 0; i < 2; i++) begin
                total++;
                if (busy[i] !== 1'b0) begin
                    bad++;
                    $display("FAIL reset_idle busy inst%0d got=%b want=0", i, busy[i]);
                end
            end
        end
    endtask

    task automatic test_hold();
        mode[0] = 0; mode[1] = 0;
        launch(8'h3C, 0, "hold");
    endtask

    task automatic test_const();
        mode[0] = 1; mode[1] = 1; const_val[0] = 8'hA5; const_val[1] = 8'hA5;
        launch(8'h0F, 0, "const");
    endtask

    task automatic test_invert();
        mode[0] = 2; mode[1] = 2;
        launch(8'h81, 0, "invert");
    endtask

    task automatic test_abort();
        mode[0] = 0; mode[1] = 0;
        @(negedge CK);
        start = 1'b1; pattern_in = 8'hC6;
        check_run(8'hC6, 12, 13, 1'b1, "abort");
        pattern_in = 8'h2B;
        check_run(8'h2B, 0, 2 * N + 4, 1'b0, "restart");
    endtask

    task automatic test_back_to_back();
        mode[0] = 0; mode[1] = 0;
        @(negedge CK);
        start = 1'b1; pattern_in = 8'h96;
        check_run(8'h96, 0, 18, 1'b0, "b2b_first");
        start = 1'b1; pattern_in = 8'h4D;
        @(negedge CK);
        total += 3;
        if (busy[0] !== 1'b0) begin bad++; $display("FAIL b2b idle busy inst0 got=%b want=0", busy[0]); end
        if (done[1] !== 1'b1) begin bad++; $display("FAIL b2b done inst1 got=%b want=1", done[1]); end
        if (resp[1] !== 8'h96) begin bad++; $display("FAIL b2b resp inst1 got=%h want=96", resp[1]); end
        exp_resp[1] = 8'h96;
        @(negedge CK);
        total += 3;
        if (busy[0] !== 1'b1) begin bad++; $display("FAIL b2b accept busy inst0 got=%b want=1", busy[0]); end
        if (si[0] !== 1'b0) begin bad++; $display("FAIL b2b first scan_in inst0 got=%b want=0", si[0]); end
        if (busy[1] !== 1'b0) begin bad++; $display("FAIL b2b not_queued busy inst1 got=%b want=0", busy[1]); end
        start = 1'b0;
        for (int c = 21; c <= 37; c++) begin
            @(negedge CK);
            total += 2;
            if (busy[1] !== 1'b0) begin bad++; $display("FAIL b2b idle inst1 cyc%0d got=%b want=0", c, busy[1]); end
            if (done[0] !== (c == 37)) begin
                bad++;
                $display("FAIL b2b done inst0 cyc%0d got=%b want=%b", c, done[0], (c == 37));
            end
        end
        total++;
        if (resp[0] !== 8'h4D) begin bad++; $display("FAIL b2b resp inst0 got=%h want=4d", resp[0]); end
        exp_resp[0] = 8'h4D;
        repeat (2) @(negedge CK);
    endtask

    task automatic test_reset_mid();
        mode[0] = 0; mode[1] = 0;
        @(negedge CK);
        start = 1'b1; pattern_in = 8'h3C;
        check_run(8'h3C, 0, 4, 1'b0, "rst_mid");
        #2 RN = 1'b0;
        #1 check_all_zero("rst_mid_async");
        exp_resp[0] = '0; exp_resp[1] = '0;
        @(negedge CK) RN = 1'b1;
        repeat (3) begin
            @(negedge CK);
            for (int i = 0; i < 2; i++) begin
                total++;
                if (busy[i] !== 1'b0 || se[i] !== 1'b0) begin
                    bad++;
                    $display("FAIL rst_mid_idle inst%0d got busy=%b se=%b want 0", i, busy[i], se[i]);
                end
            end
        end
        launch(8'h3C, 0, "rst_mid_rerun");
    endtask

    task automatic test_random();
        int a;
        logic [N-1:0] pat;
        for (int it = 0; it < 24; it++) begin
            for (int i = 0; i < 2; i++) begin
                mode[i]      = $urandom_range(0, 2);
                const_val[i] = N'($urandom);
            end
            pat = N'($urandom);
            a = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2 * N + 2) : 0;
`ifdef SCAN_CHAIN_CTRL_COMPARE_EN
            expected = ($urandom_range(0, 1) == 0) ? pat : N'($urandom);
`endif
            launch(pat, a, "random");
        end
    endtask

`ifdef SCAN_CHAIN_CTRL_COMPARE_EN
    task automatic test_compare();
        mode[0] = 0; mode[1] = 0;
        expected = 8'h55;
        launch(8'h55, 0, "cmp_match");
        expected = 8'h54;
        launch(8'h55, 0, "cmp_miss");
    endtask
`endif

    initial begin
        test_reset();
        test_hold();
        test_const();
        test_invert();
        test_abort();
        test_back_to_back();
        test_reset_mid();
`ifdef SCAN_CHAIN_CTRL_COMPARE_EN
        test_compare();
`endif
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/scan_chain_ctrl.md
Name: scan_chain_ctrl

Overview:
- Sequencer for one serial scan chain built from scan flip-flops with SE/SI pins, SI of flop k+1 driven from Q of flop k.
- Per test pattern it performs three phases: shift the pattern in, run the capture cycle(s), then shift the captured response out.
- Sits between a pattern source (BIST engine or tester interface) and the chain's SE/SI/SO pins.

Parameters:
- CHAIN_LEN, 8, number of flops in the chain (>=2).
- CNT_W, 4, bit-counter width; must satisfy 2**CNT_W > CHAIN_LEN.
- CAPTURE_CYC, 1, number of functional-mode (SE=0) capture cycles (1..2**CNT_W-1).

Ports:
- CK  input  1  clock; all state updates on the rising edge.
- RN  input  1  asynchronous active-low reset.
- start  input  1  request one pattern; sampled only in IDLE.
- abort  input  1  synchronous abort; returns the FSM to IDLE next edge.
- pattern_in  input  CHAIN_LEN  pattern to load; latched on an accepted start.
- scan_out  input  1  SO from the last flop of the chain.
- scan_en  output  1  drives SE of every chain flop.
- scan_in  output  1  drives SI of the first chain flop.
- busy  output  1  high in SHIFT, CAPTURE and UNLOAD.
- done  output  1  one-cycle pulse, in DONE state.
- response  output  CHAIN_LEN  unloaded chain contents; valid from the done pulse until the next accepted start.

Behaviour:
- All outputs are registered.
- Reset (RN=0, asynchronous): state=IDLE, scan_en=0, scan_in=0, busy=0, done=0, response=0, counters=0, pattern register=0.
- FSM states: IDLE, SHIFT, CAPTURE, UNLOAD, DONE.
- IDLE:
  - start=1 at an edge latches pattern_in and moves to SHIFT.
  - start while in any other state is ignored; it is not queued.
- SHIFT, exactly CHAIN_LEN cycles:
  - scan_en=1.
  - scan_in presents pattern bits MSB first: cycle i drives pattern[CHAIN_LEN-1-i].
  - After the last shift edge, pattern[0] sits in flop 0 and pattern[CHAIN_LEN-1] in the last flop.
  - scan_out is ignored in this state.
- CAPTURE, exactly CAPTURE_CYC cycles: scan_en=0, scan_in=0.
- UNLOAD, exactly CHAIN_LEN cycles:
  - scan_en=1, scan_in=0 (zero fill).
  - At each edge, scan_out is sampled into the response shift register LSB and the register shifts left.
  - The first sampled bit (last flop) ends as response[CHAIN_LEN-1].
  - response updates only on the final UNLOAD edge; the internal accumulator is separate from the response output.
- DONE, 1 cycle: done=1, busy=0, scan_en=0, then go to IDLE.
- Latency:
  - The start edge is cycle 0; busy rises at cycle 1.
  - done is high in cycle 2*CHAIN_LEN+CAPTURE_CYC+1.
  - A back-to-back start may be asserted during DONE; it is accepted on the next edge in IDLE.
- abort=1 in SHIFT/CAPTURE/UNLOAD:
  - Next edge: state=IDLE, scan_en=0, busy=0, no done pulse, response unchanged.
  - abort has priority over start and over phase completion at the same edge.
  - abort in IDLE or DONE has no effect.
- Reset mid-operation: immediate return to reset values; the chain contents are undefined to the caller.
- Counter terminal checks use count==CHAIN_LEN-1 and count==CAPTURE_CYC-1; the counter clears on every phase change. There is no wrap-around inside a phase.

Optional Feature:
- Macro: SCAN_CHAIN_CTRL_COMPARE_EN.
- Defined:
  - Adds input expected[CHAIN_LEN-1:0], latched with pattern_in on start.
  - Adds output mismatch (1 bit), registered at the final UNLOAD edge as OR of (response XOR expected). It is valid with done, cleared on accepted start, and reset to 0.
- Undefined: neither port exists; behaviour is otherwise identical.

Test Plan:
- Reset: RN=0 mid-SHIFT with pattern 8'h3C -> scan_en, busy, done and response go to 0 asynchronously; after RN=1 the FSM idles until start.
- Hold chain (each flop D=own Q), CAPTURE_CYC=1, pattern 8'h3C -> done at cycle 18; response=8'h3C; scan_en low only in cycles 9 and 18.
- Constant capture (D inputs tied to 8'hA5), pattern 8'h0F -> response=8'hA5; scan_in sequence during SHIFT is 0,0,0,0,1,1,1,1.
- Inverting chain (D=~Q), CAPTURE_CYC=2, pattern 8'h81 -> response=8'h81 (double inversion); done at cycle 19.
- Abort in UNLOAD cycle 3 -> next edge busy=0, no done, response holds its previous value; a start held high throughout is re-accepted one edge after IDLE is reached.
- Compare macro on, hold chain, pattern 8'h55, expected 8'h55 -> mismatch=0; then expected 8'h54 -> mismatch=1 with done.
